// File: rtl/mx_int8_sum_seq_if.sv
// mx_int8_sum_seq_if
// Groups the element-beat input stream and the result output stream of the
// MXINT8 block summer into one bundle.
//   in_valid/in_ready  : element beat handshake (producer -> summer)
//   in_scale           : E8M0 block scale, meaningful on beat 0 only
//   in_elem            : signed two's-complement element
//   out_valid/out_ready: result handshake (summer -> consumer)
//   out_scale, out_sum, out_nan : result scale, element and NaN flag
// Modports: master = the side feeding beats and consuming results,
//           slave  = the summer itself.
interface mx_int8_sum_seq_if #(
  parameter int SCALE_W = 8,
  parameter int ELEM_W  = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [SCALE_W-1:0] in_scale;
  logic [ELEM_W-1:0]  in_elem;
  logic               out_valid;
  logic               out_ready;
  logic [SCALE_W-1:0] out_scale;
  logic [ELEM_W-1:0]  out_sum;
  logic               out_nan;

  modport master (
    output in_valid, in_scale, in_elem, out_ready,
    input  in_ready, out_valid, out_scale, out_sum, out_nan
  );

  modport slave (
    input  in_valid, in_scale, in_elem, out_ready,
    output in_ready, out_valid, out_scale, out_sum, out_nan
  );
endinterface

// File: rtl/mx_int8_sum_seq.sv
// mx_int8_sum_seq
// Sums one MX block of BLOCK_SIZE signed MXINT8 elements sharing an E8M0
// scale, then renormalises the sum back into an 8-bit element by arithmetic
// right shifts, bumping the scale once per shift. A scale that ends at or
// above the all-ones code is reported as NaN.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   mx    : mx_int8_sum_seq_if.slave (beat stream in, result stream out)
// Optional feature macro: MXINT8_SUM_NAN_CHECK_EN
//   When defined, a block scale of all-ones or any element equal to the
//   most-negative code marks the block as NaN. When undefined, those codes
//   are ordinary values and only scale overflow yields NaN.
module mx_int8_sum_seq #(
  parameter int BLOCK_SIZE = 32,
  parameter int SCALE_W    = 8,
  parameter int ELEM_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  mx_int8_sum_seq_if.slave mx
);

  // 13 bits holds 32 x (-128) exactly; larger blocks would need a wider sum.
  localparam int ACC_W = 13;
  localparam int CNT_W = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;

  localparam logic signed [ACC_W-1:0] ACC_MAX   = ACC_W'((1 << (ELEM_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] ACC_MIN   = -ACC_MAX;
  localparam logic [CNT_W-1:0]        LAST_BEAT = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [SCALE_W:0]        SCALE_NAN = {1'b0, {SCALE_W{1'b1}}};
  localparam logic [ELEM_W-1:0]       ELEM_NAN  = {1'b1, {(ELEM_W - 1){1'b0}}};

  typedef enum logic [1:0] {
    ACC,
    NORM,
    OUT
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [SCALE_W:0]        scale_q, scale_d;
  logic                    nan_q, nan_d;

  logic                    beat_fire;
  logic                    beat_nan;
  logic                    in_range;
  logic                    res_nan;
  logic signed [ACC_W-1:0] elem_ext;

  assign mx.in_ready = (state_q == ACC);
  assign beat_fire   = mx.in_valid && mx.in_ready;
  assign elem_ext    = {{(ACC_W - ELEM_W){mx.in_elem[ELEM_W-1]}}, mx.in_elem};
  assign in_range    = (acc_q <= ACC_MAX) && (acc_q >= ACC_MIN);

`ifdef MXINT8_SUM_NAN_CHECK_EN
  // The scale only counts on beat 0, where it is captured.
  assign beat_nan = (mx.in_elem == ELEM_NAN) ||
                    ((cnt_q == '0) && (mx.in_scale == {SCALE_W{1'b1}}));
`else
  assign beat_nan = 1'b0;
`endif

  // Scale can climb past the all-ones code during normalisation; the extra
  // scale bit lets that overflow be seen instead of wrapping.
  assign res_nan = nan_q || (scale_q >= SCALE_NAN);

  // Outputs come straight from the block registers, so they are frozen for
  // as long as the FSM sits in OUT and read as zero straight out of reset.
  assign mx.out_valid = (state_q == OUT);
  assign mx.out_nan   = res_nan;
  assign mx.out_scale = res_nan ? {SCALE_W{1'b1}} : scale_q[SCALE_W-1:0];
  assign mx.out_sum   = res_nan ? ELEM_NAN : acc_q[ELEM_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      scale_q <= '0;
      nan_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      scale_q <= scale_d;
      nan_q   <= nan_d;
    end
  end

  // Beat 0 overwrites the accumulator, scale and NaN flag, so no separate
  // clear is needed between blocks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    scale_d = scale_q;
    nan_d   = nan_q;
    case (state_q)
      ACC: begin
        if (beat_fire) begin
          if (cnt_q == '0) begin
            acc_d   = elem_ext;
            scale_d = {1'b0, mx.in_scale};
            nan_d   = beat_nan;
          end else begin
            acc_d = acc_q + elem_ext;
            nan_d = nan_q || beat_nan;
          end
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = NORM;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      NORM: begin
        // >>> on a signed value floors, so negative sums round toward -inf.
        if (!in_range) begin
          acc_d   = acc_q >>> 1;
          scale_d = scale_q + 1'b1;
        end else begin
          state_d = OUT;
        end
      end
      OUT: begin
        if (mx.out_ready) begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase
  end

endmodule

// File: tb/tb_mx_int8_sum_seq.sv
// tb_mx_int8_sum_seq
// Directed bench for mx_int8_sum_seq with BLOCK_SIZE=32. A table of whole
// blocks (scale, fill element, one optional special element, gap spacing,
// hold cycles) with hand-computed results is replayed back to back, then
// hand-written sequences cover reset in the middle of a block and in the
// middle of normalisation.
module tb_mx_int8_sum_seq;

  localparam int BLOCK = 32;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  mx_int8_sum_seq_if #(.SCALE_W(8), .ELEM_W(8)) mx ();

  mx_int8_sum_seq #(
    .BLOCK_SIZE(BLOCK),
    .SCALE_W   (8),
    .ELEM_W    (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mx   (mx)
  );

  typedef struct {
    logic [7:0] scale;
    logic [7:0] elemA;
    int         idx;
    logic [7:0] val;
    int         gap;
    int         hold;
    logic [7:0] expSum;
    logic [7:0] expScale;
    logic       expNan;
    int         expLat;
  } vec_t;

  vec_t vecs [11];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives n beats starting at beat 0; returns #1 after the last accepting edge
  // with in_valid still high. Gap cycles carry junk that must not be taken.
  task automatic sendPartial(input logic [7:0] scale, input logic [7:0] elemA,
                             input int idx, input logic [7:0] val,
                             input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      if (gap != 0 && i != 0 && (i % gap) == 0) begin
        mx.in_valid = 1'b0;
        mx.in_elem  = 8'h80;
        mx.in_scale = 8'hFF;
        @(posedge clk); #1;
      end
      mx.in_valid = 1'b1;
      mx.in_scale = (i == 0) ? scale : 8'hEE;
      mx.in_elem  = (i == idx) ? val : elemA;
      @(posedge clk); #1;
    end
  endtask

  task automatic applyStimulus(input int vi, input vec_t v);
    int         lat;
    logic [7:0] heldSum;
    logic [7:0] heldScale;
    logic       heldNan;
    sendPartial(v.scale, v.elemA, v.idx, v.val, BLOCK, v.gap);
    // Keep offering junk while the block is busy; it must be ignored.
    mx.in_elem  = 8'h7F;
    mx.in_scale = 8'hFF;
    checkOutput($sformatf("v%0d_ready_low", vi), 32'(mx.in_ready), 32'd0);
    lat = 0;
    while (!mx.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput($sformatf("v%0d_latency", vi), 32'(lat), 32'(v.expLat));
    checkOutput($sformatf("v%0d_sum", vi), 32'(mx.out_sum), 32'(v.expSum));
    checkOutput($sformatf("v%0d_scale", vi), 32'(mx.out_scale), 32'(v.expScale));
    checkOutput($sformatf("v%0d_nan", vi), 32'(mx.out_nan), 32'(v.expNan));
    heldSum   = v.expSum;
    heldScale = v.expScale;
    heldNan   = v.expNan;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_hold%0d_valid", vi, h), 32'(mx.out_valid), 32'd1);
      checkOutput($sformatf("v%0d_hold%0d_sum", vi, h), 32'(mx.out_sum), 32'(heldSum));
      checkOutput($sformatf("v%0d_hold%0d_scale", vi, h), 32'(mx.out_scale), 32'(heldScale));
      checkOutput($sformatf("v%0d_hold%0d_nan", vi, h), 32'(mx.out_nan), 32'(heldNan));
      checkOutput($sformatf("v%0d_hold%0d_ready", vi, h), 32'(mx.in_ready), 32'd0);
    end
    mx.out_ready = 1'b1;
    @(posedge clk); #1;
    mx.out_ready = 1'b0;
    mx.in_valid  = 1'b0;
    checkOutput($sformatf("v%0d_valid_drop", vi), 32'(mx.out_valid), 32'd0);
    checkOutput($sformatf("v%0d_ready_back", vi), 32'(mx.in_ready), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(mx.out_valid), 32'd0);
    checkOutput({tag, "_out_sum"}, 32'(mx.out_sum), 32'd0);
    checkOutput({tag, "_out_scale"}, 32'(mx.out_scale), 32'd0);
    checkOutput({tag, "_out_nan"}, 32'(mx.out_nan), 32'd0);
  endtask

  initial begin
    vec_t rv;
    total = 0;
    bad   = 0;

    //           scale  elemA  idx val    gap hold sum    scale  nan  lat
    vecs[0]  = '{8'h7F, 8'h01, -1, 8'h00, 0,  0,   8'h20, 8'h7F, 1'b0, 1};
    vecs[1]  = '{8'h64, 8'h7F, -1, 8'h00, 0,  3,   8'h7F, 8'h69, 1'b0, 6};
    vecs[2]  = '{8'h64, 8'h81, -1, 8'h00, 0,  0,   8'h81, 8'h69, 1'b0, 6};
    vecs[3]  = '{8'hFB, 8'h7F, -1, 8'h00, 0,  1,   8'h80, 8'hFF, 1'b1, 6};
`ifdef MXINT8_SUM_NAN_CHECK_EN
    vecs[4]  = '{8'h0A, 8'h00, 7,  8'h80, 0,  0,   8'h80, 8'hFF, 1'b1, 2};
`else
    vecs[4]  = '{8'h0A, 8'h00, 7,  8'h80, 0,  0,   8'hC0, 8'h0B, 1'b0, 2};
`endif
    vecs[5]  = '{8'h42, 8'h00, -1, 8'h00, 5,  0,   8'h00, 8'h42, 1'b0, 1};
    vecs[6]  = '{8'hFF, 8'h01, -1, 8'h00, 0,  0,   8'h80, 8'hFF, 1'b1, 1};
    vecs[7]  = '{8'hF9, 8'h7F, -1, 8'h00, 0,  0,   8'h7F, 8'hFE, 1'b0, 6};
`ifdef MXINT8_SUM_NAN_CHECK_EN
    vecs[8]  = '{8'h14, 8'h80, -1, 8'h00, 0,  0,   8'h80, 8'hFF, 1'b1, 7};
`else
    vecs[8]  = '{8'h14, 8'h80, -1, 8'h00, 0,  0,   8'hC0, 8'h1A, 1'b0, 7};
`endif
    vecs[9]  = '{8'h05, 8'h00, 0,  8'h7F, 0,  0,   8'h7F, 8'h05, 1'b0, 1};
    vecs[10] = '{8'h03, 8'h04, 5,  8'h08, 3,  0,   8'h42, 8'h04, 1'b0, 2};

    mx.in_valid  = 1'b0;
    mx.in_scale  = 8'h00;
    mx.in_elem   = 8'h00;
    mx.out_ready = 1'b0;
    rst_n        = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("por");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("por_in_ready", 32'(mx.in_ready), 32'd1);

    $display("[TB] table vectors");
    for (int k = 0; k < 11; k++) begin
      applyStimulus(k, vecs[k]);
    end

    $display("[TB] reset mid-block");
    sendPartial(8'h09, 8'h11, -1, 8'h00, 16, 3);
    mx.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkResetValues("rst_mid_block");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_block_in_ready", 32'(mx.in_ready), 32'd1);
    rv = '{8'h32, 8'h02, -1, 8'h00, 0, 0, 8'h40, 8'h32, 1'b0, 1};
    applyStimulus(20, rv);

    $display("[TB] reset mid-normalise");
    sendPartial(8'h64, 8'h7F, -1, 8'h00, BLOCK, 0);
    mx.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mid_norm_pre_valid", 32'(mx.out_valid), 32'd0);
    rst_n = 1'b0;
    #1;
    checkResetValues("rst_mid_norm");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_mid_norm_in_ready", 32'(mx.in_ready), 32'd1);
    rv = '{8'h03, 8'h01, -1, 8'h00, 0, 0, 8'h20, 8'h03, 1'b0, 1};
    applyStimulus(21, rv);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mx_int8_sum_seq.md
MX_INT8_SUM_SEQ -- requirements
Module: mx_int8_sum_seq

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter BLOCK_SIZE, default 32: number of elements per MX block.
REQ-003 Parameter SCALE_W, default 8: E8M0 shared-scale width.
REQ-004 Parameter ELEM_W, default 8: MXINT8 element width.
REQ-005 Port clk, input, 1 bit: clock, rising edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port in_valid, input, 1 bit: element beat valid.
REQ-008 Port in_ready, output, 1 bit: element beat accepted when in_valid and in_ready are both high.
REQ-009 Port in_scale, input, SCALE_W bits: block scale, sampled only on beat 0.
REQ-010 Port in_elem, input, ELEM_W bits: signed two's-complement element.
REQ-011 Port out_valid, output, 1 bit: result valid.
REQ-012 Port out_ready, input, 1 bit: result consumed when out_valid and out_ready are both high.
REQ-013 Port out_scale, output, SCALE_W bits: result scale.
REQ-014 Port out_sum, output, ELEM_W bits: signed result element.
REQ-015 Port out_nan, output, 1 bit: result is NaN.

Function
REQ-016 The FSM SHALL have three states: ACC, NORM and OUT; it SHALL reset to ACC.
REQ-017 In ACC: in_ready=1; each accepted beat SHALL add the sign-extended in_elem to a 13-bit signed accumulator and increment a beat counter (0..BLOCK_SIZE-1); beat 0 SHALL load the accumulator (not add to it) and capture in_scale.
REQ-018 Acceptance of beat BLOCK_SIZE-1 SHALL wrap the counter to 0 and move the FSM to NORM next cycle.
REQ-019 In NORM: in_ready=0; while the accumulator is outside [-127,127], it SHALL shift the accumulator arithmetically right by 1 (floor) and increment the captured scale (9-bit internal), one shift per cycle; when the accumulator is in range, it SHALL go to OUT.
REQ-020 Latency: out_valid SHALL rise 1+k cycles after the last beat is accepted, where k is the shift count (0..6).
REQ-021 Scale overflow: if the final scale is >=0xFF, outputs SHALL be out_nan=1, out_scale=0xFF, out_sum=0x80.
REQ-022 Zero sum: out_sum=0x00 and out_scale=the captured scale, with no downward normalisation.
REQ-023 In OUT: out_valid=1; out_scale, out_sum and out_nan SHALL stay stable until out_ready; on handshake, go to ACC the next cycle with out_valid=0.
REQ-024 in_ready SHALL be 0 in NORM and OUT; no beat is accepted and no input is sampled there.
REQ-025 in_valid=0 in ACC SHALL hold all state, including a partially accumulated block.

Reset
REQ-026 Asserting rst_n low SHALL immediately clear the FSM to ACC, the counter, the accumulator, the captured scale and the NaN flag.
REQ-027 Reset values SHALL be: out_valid=0, out_scale=0x00, out_sum=0x00, out_nan=0; in_ready=1 once reset is released.
REQ-028 Reset mid-block or mid-NORM SHALL discard the partial block; the next accepted beat is beat 0.

Configuration
REQ-029 Macro MXINT8_SUM_NAN_CHECK_EN, when defined: a captured in_scale==0xFF or any accepted in_elem==0x80 SHALL set a sticky per-block flag, and the result SHALL be out_nan=1, out_scale=0xFF, out_sum=0x80, with the same latency as REQ-020.
REQ-030 Macro MXINT8_SUM_NAN_CHECK_EN, when undefined: 0x80 SHALL be summed as -128, scale 0xFF SHALL be treated as an ordinary value, and only REQ-021 SHALL produce NaN.

Verification (BLOCK_SIZE=32)
REQ-031 in_scale=127, all elements 0x01, continuous valid -> out_sum=32, out_scale=127, out_nan=0, out_valid 1 cycle after beat 31.
REQ-032 in_scale=100, all elements 127 -> accumulator 4064, 5 shifts -> out_sum=127, out_scale=105, out_valid 6 cycles after beat 31.
REQ-033 in_scale=100, all elements -127 -> out_sum=0x81 (-127), out_scale=105; in_scale=0xFB, all elements 127 -> out_nan=1, out_scale=0xFF, out_sum=0x80.
REQ-034 With the macro defined, in_scale=10 and element 7=0x80 -> out_nan=1, out_scale=0xFF, out_sum=0x80; without the macro, same stimulus with all others 0x00 -> out_sum=0x80 shifted to -64 (0xC0), out_scale=11.
REQ-035 Result held with out_ready=0 for 3 cycles -> outputs stable, in_ready=0; back-to-back block accepted the cycle after the handshake.
REQ-036 rst_n pulsed low after beat 15 with in_valid gaps -> outputs at reset values; a following full block of 0x02 with scale 50 -> out_sum=64, out_scale=50.
